// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: decodes the IR and sequences the datapath.
// Optional ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP and raise illegal_instr.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic        RegWrite,
    output logic [9:0]  ALUControl,
    output logic        illegal_instr,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [9:0] ALU_ADD = 10'h000;
    localparam logic [9:0] ALU_BEQ = 10'h008;
    localparam logic [9:0] ALU_BNE = 10'h009;

`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] S_ILLEGAL = S_TRAP;
`else
    localparam logic [3:0] S_ILLEGAL = S_FETCH;
`endif

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [2:0] w_imm_src;
    logic [6:0] w_op;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;

    assign w_op     = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= RESET_STATE;
        else       r_state <= w_next;
    end

    // Next-state sequencing; mem_ready gates the three memory-facing states.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BRANCH:         w_next = (w_funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (w_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BRANCH:   w_next = S_FETCH;
            S_LUI:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (w_op)
            OP_STORE:  w_imm_src = 3'b001;
            OP_BRANCH: w_imm_src = 3'b010;
            OP_JAL:    w_imm_src = 3'b011;
            OP_LUI:    w_imm_src = 3'b100;
            default:   w_imm_src = 3'b000;
        endcase
    end

    // Control outputs decoded from state and instruction; reset masks all write enables.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        ALUControl = ALU_ADD;
        ImmSrc     = w_imm_src;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = {w_funct7, w_funct3};
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = {(w_funct3 == 3'b101) ? w_funct7 : 7'b0, w_funct3};
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_funct3[0] ? ALU_BNE : ALU_BEQ;
                PCWrite    = Zero;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (reset)                                          r_illegal <= 1'b0;
        else if (r_state == S_DECODE && w_next == S_TRAP)  r_illegal <= 1'b1;
    end

    assign illegal_instr = r_illegal;
`else
    assign illegal_instr = 1'b0;
`endif

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, corner sequences, random vs model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] imm;
        logic       regw;
        logic [9:0] aluc;
        logic       ill;
        logic [3:0] st;
    } ctrl_t;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic [3:0]  xst;
        logic [9:0]  alu;
        logic        pcw;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [9:0]  ALUControl;
    logic [3:0]  state;

    int          n_vec = 0;
    int          n_err = 0;
    logic        model_ill = 1'b0;
    logic [3:0]  seq_q[$];
    vec_t        tbl[13];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal_instr(illegal_instr),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t act_ctrl();
        ctrl_t c;
        c.pcw = PCWrite;   c.adr = AdrSrc;    c.memw = MemWrite; c.irw = IRWrite;
        c.res = ResultSrc; c.srca = ALUSrcA;  c.srcb = ALUSrcB;  c.imm = ImmSrc;
        c.regw = RegWrite; c.aluc = ALUControl; c.ill = illegal_instr; c.st = state;
        return c;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    // Expected control word for one step of an instruction's path.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [31:0] ins,
                                       input logic mr, input logic z, input logic rst,
                                       input logic ill);
        ctrl_t c;
        logic [2:0] f3;
        logic [6:0] f7;
        c = '0;
        f3 = ins[14:12];
        f7 = ins[31:25];
        c.st = st;
        c.ill = ill;
        c.imm = imm_of(ins[6:0]);
        case (st)
            4'd0:  begin c.srcb = 2'd2; c.res = 2'd2; c.irw = mr; c.pcw = mr; end
            4'd1:  begin c.srca = 2'd1; c.srcb = 2'd1; end
            4'd2:  begin c.srca = 2'd2; c.srcb = 2'd1; end
            4'd3:  c.adr = 1'b1;
            4'd4:  begin c.res = 2'd1; c.regw = 1'b1; end
            4'd5:  begin c.adr = 1'b1; c.memw = 1'b1; end
            4'd6:  begin c.srca = 2'd2; c.aluc = {f7, f3}; end
            4'd7:  begin c.srca = 2'd2; c.srcb = 2'd1; c.aluc = (f3 == 3'd5) ? {f7, f3} : {7'd0, f3}; end
            4'd8:  c.regw = 1'b1;
            4'd9:  begin c.srca = 2'd1; c.srcb = 2'd2; c.pcw = 1'b1; end
            4'd10: begin c.srca = 2'd2; c.aluc = (f3 == 3'd0) ? 10'h008 : 10'h009; c.pcw = z; end
            4'd11: begin c.srca = 2'd3; c.srcb = 2'd1; end
            default: ;
        endcase
        if (rst) begin c.pcw = 1'b0; c.irw = 1'b0; c.regw = 1'b0; c.memw = 1'b0; end
        return c;
    endfunction

    // Step path of an instruction by class, assuming no stalls.
    task automatic build_seq(input logic [31:0] ins);
        bit bad;
        bad = 1'b0;
        seq_q.delete();
        seq_q.push_back(4'd0);
        seq_q.push_back(4'd1);
        case (ins[6:0])
            7'b0000011: begin seq_q.push_back(4'd2); seq_q.push_back(4'd3); seq_q.push_back(4'd4); end
            7'b0100011: begin seq_q.push_back(4'd2); seq_q.push_back(4'd5); end
            7'b0110011: begin seq_q.push_back(4'd6); seq_q.push_back(4'd8); end
            7'b0010011: begin seq_q.push_back(4'd7); seq_q.push_back(4'd8); end
            7'b1101111: begin seq_q.push_back(4'd9); seq_q.push_back(4'd8); end
            7'b1100011: if (ins[14:12] < 3'd2) seq_q.push_back(4'd10); else bad = 1'b1;
            7'b0110111: begin seq_q.push_back(4'd11); seq_q.push_back(4'd8); end
            default:    bad = 1'b1;
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (bad) seq_q.push_back(4'd12);
`else
        if (bad) seq_q.push_back(4'd0);
        if (bad) void'(seq_q.pop_back());
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        model_ill = 1'b0;
        #2;
        chk("reset_ctrl", {3'b0, act_ctrl()}, {3'b0, exp_ctrl(4'd0, instr, 1'b1, Zero, 1'b1, 1'b0)});
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_model(input logic [31:0] ins, input bit rnd);
        int k, stalls, trap_cyc;
        logic [3:0] st;
        logic mr, z;
        k = 0; stalls = 0; trap_cyc = 0;
        build_seq(ins);
        instr = ins;
        while (k < seq_q.size()) begin
            st = seq_q[k];
            mr = 1'b1;
            if (rnd && stalls < 3 && (st == 4'd0 || st == 4'd3 || st == 4'd5))
                mr = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            mem_ready = mr;
            Zero = z;
            #3;
            chk("model_step", {3'b0, act_ctrl()}, {3'b0, exp_ctrl(st, ins, mr, z, 1'b0, model_ill)});
            @(posedge clk); #1;
            if (st == 4'd12) begin
                trap_cyc++;
                if (trap_cyc == 3) k = seq_q.size();
            end else if ((st == 4'd0 || st == 4'd3 || st == 4'd5) && !mr) begin
                stalls++;
            end else begin
                k++;
                if (k < seq_q.size() && seq_q[k] == 4'd12) model_ill = 1'b1;
            end
        end
        if (seq_q[seq_q.size() - 1] == 4'd12) do_reset();
    endtask

    task automatic run_table();
        int n;
        logic [9:0] g_alu;
        logic g_pcw;
        for (int i = 0; i < $size(tbl); i++) begin
            n = 0; g_alu = 10'h3FF; g_pcw = 1'bx;
            instr = tbl[i].ins; Zero = tbl[i].z; mem_ready = 1'b1;
            do begin
                #3;
                if (state == tbl[i].xst) begin g_alu = ALUControl; g_pcw = PCWrite; end
                @(posedge clk); #1;
                n++;
            end while (state != 4'd0 && n < 20);
            chk("tbl_alucontrol", 32'(g_alu), 32'(tbl[i].alu));
            chk("tbl_pcwrite", 32'(g_pcw), 32'(tbl[i].pcw));
            chk("tbl_cycles", 32'(n), 32'(tbl[i].cyc));
        end
    endtask

    task automatic hand_lw_stall();
        int n, stall, wb;
        n = 0; stall = 0; wb = 0;
        instr = 32'h0000A183; Zero = 1'b0;
        do begin
            mem_ready = 1'b1;
            if (state == 4'd3 && stall < 3) begin mem_ready = 1'b0; stall++; end
            #3;
            if (RegWrite && ResultSrc == 2'b01) wb++;
            @(posedge clk); #1;
            n++;
        end while (state != 4'd0 && n < 30);
        chk("lw_stall_cycles", 32'(n), 32'd8);
        chk("lw_writeback_count", 32'(wb), 32'd1);
    endtask

    task automatic hand_sw_stall();
        int n, stall, mw, bad_adr;
        n = 0; stall = 0; mw = 0; bad_adr = 0;
        instr = 32'h0020A023; Zero = 1'b0;
        do begin
            mem_ready = 1'b1;
            if (state == 4'd5 && stall < 2) begin mem_ready = 1'b0; stall++; end
            #3;
            if (MemWrite) begin mw++; if (!AdrSrc) bad_adr++; end
            @(posedge clk); #1;
            n++;
        end while (state != 4'd0 && n < 30);
        mem_ready = 1'b1;
        chk("sw_memwrite_cycles", 32'(mw), 32'd3);
        chk("sw_adrsrc_low", 32'(bad_adr), 32'd0);
        chk("sw_total_cycles", 32'(n), 32'd6);
    endtask

    task automatic hand_reset_mid();
        instr = 32'h0000A183; mem_ready = 1'b1; Zero = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_pre_state", 32'(state), 32'd4);
        reset = 1'b1;
        #2;
        chk("rst_mid_ctrl", {3'b0, act_ctrl()}, {3'b0, exp_ctrl(4'd4, instr, 1'b1, 1'b0, 1'b1, 1'b0)});
        @(posedge clk); #1;
        chk("rst_mid_state", 32'(state), 32'd0);
        reset = 1'b0;
    endtask

    task automatic hand_illegal();
        instr = 32'h0000007F; mem_ready = 1'b1; Zero = 1'b0;
        @(posedge clk); #3;
        chk("illegal_decode", {3'b0, act_ctrl()}, {3'b0, exp_ctrl(4'd1, instr, 1'b1, 1'b0, 1'b0, 1'b0)});
        @(posedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
        chk("illegal_trap_state", 32'(state), 32'd12);
        chk("illegal_flag_set", 32'(illegal_instr), 32'd1);
        @(posedge clk); #1;
        chk("illegal_trap_hold", {3'b0, act_ctrl()}, {3'b0, exp_ctrl(4'd12, instr, 1'b1, 1'b0, 1'b0, 1'b1)});
        do_reset();
        chk("illegal_cleared", 32'(illegal_instr), 32'd0);
`else
        chk("illegal_nop_state", 32'(state), 32'd0);
        chk("illegal_flag_low", 32'(illegal_instr), 32'd0);
`endif
    endtask

    initial begin
        logic [6:0]  ops[10];
        logic [31:0] ins;

        tbl[0]  = '{32'h002081B3, 1'b0, 4'd6,  10'h000, 1'b0, 4};
        tbl[1]  = '{32'h402081B3, 1'b0, 4'd6,  10'h100, 1'b0, 4};
        tbl[2]  = '{32'h0020C1B3, 1'b0, 4'd6,  10'h004, 1'b0, 4};
        tbl[3]  = '{32'h4030D193, 1'b0, 4'd7,  10'h105, 1'b0, 4};
        tbl[4]  = '{32'h00108093, 1'b0, 4'd7,  10'h000, 1'b0, 4};
        tbl[5]  = '{32'h40008093, 1'b0, 4'd7,  10'h000, 1'b0, 4};
        tbl[6]  = '{32'h00109093, 1'b0, 4'd7,  10'h001, 1'b0, 4};
        tbl[7]  = '{32'h00208063, 1'b1, 4'd10, 10'h008, 1'b1, 3};
        tbl[8]  = '{32'h00209063, 1'b0, 4'd10, 10'h009, 1'b0, 3};
        tbl[9]  = '{32'h000000EF, 1'b0, 4'd9,  10'h000, 1'b1, 4};
        tbl[10] = '{32'h000010B7, 1'b0, 4'd11, 10'h000, 1'b0, 4};
        tbl[11] = '{32'h0020A023, 1'b0, 4'd5,  10'h000, 1'b0, 4};
        tbl[12] = '{32'h0000A183, 1'b0, 4'd3,  10'h000, 1'b0, 5};

        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63, 7'h37, 7'h7F, 7'h67, 7'h00};

        reset = 1'b1; mem_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #3;
            chk("reset_hold", {3'b0, act_ctrl()}, {3'b0, exp_ctrl(4'd0, instr, 1'b1, Zero, 1'b1, 1'b0)});
        end
        @(posedge clk); #1;
        reset = 1'b0;

        run_model(32'h002081B3, 1'b0);
        run_table();
        hand_lw_stall();
        hand_sw_stall();
        hand_reset_mid();
        hand_illegal();

        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            run_model(ins, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM of the multicycle RV32I core. Initiator side of the ALU interface: drives the 10-bit ALUControl and the operand selects, and consumes Zero.
- Decodes the instruction register, sequences fetch, decode, execute, memory and writeback, and raises every datapath enable.
- Sits between the instruction register / memory port and the datapath muxes, ALU and register file.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- instr  input  32  instruction register contents (op=[6:0], funct3=[14:12], funct7=[31:25])
- Zero  input  1  ALU branch condition (1 = branch taken, for both BEQ and BNE codes)
- mem_ready  input  1  memory handshake; 1 = read data valid / write accepted this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register / OldPC enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- ImmSrc  output  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- RegWrite  output  1  register file write enable
- ALUControl  output  10  ALU op code, formed as {funct7, funct3}
- illegal_instr  output  1  sticky illegal-instruction flag
- state  output  4  current FSM state, for debug

Behaviour:
- State is registered; all control outputs decode combinationally from state and instr.
- Reset:
  - state = FETCH on the clock edge where reset = 1; illegal_instr = 0.
  - While reset = 1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- ALU op codes: ADD 0x000, SUB 0x100, SLL 0x001, SLT 0x002, SLTU 0x003, XOR 0x004, SRL 0x005, SRA 0x105, OR 0x006, AND 0x007, BEQ 0x008, BNE 0x009.
- ImmSrc decodes from op in every state: lw/I-ALU/jalr → 000; sw → 001; branch → 010; jal → 011; lui → 100.
- Default values in every state: all enables 0, ALUControl = ADD, selects 00.
- States and outputs:
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ADD. IRWrite = PCWrite = mem_ready. Stay in FETCH while mem_ready = 0; otherwise go to DECODE.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ADD (precomputes the branch target). Next state by op:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 with funct3 000 or 001 → BRANCH
    - 0110111 → LUI
    - anything else → illegal path
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ADD. Next is MEMREAD if op = 0000011, else MEMWRITE.
  - MEMREAD(3): AdrSrc=1. Hold until mem_ready, then MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE(5): AdrSrc=1, MemWrite=1. MemWrite stays high until the cycle with mem_ready = 1, then FETCH.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUControl={funct7, funct3} → ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01. ALUControl={funct3==101 ? funct7 : 7'b0, funct3} → ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1 → FETCH.
  - JAL(9): ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1 → ALUWB (rd = OldPC+4).
  - BRANCH(10): ALUSrcA=10, ALUSrcB=00, ResultSrc=00. ALUControl = BEQ if funct3 = 000, BNE if 001. PCWrite = Zero → FETCH.
  - LUI(11): ALUSrcA=11, ALUSrcB=01, ADD → ALUWB.
  - TRAP(12): all enables 0; stays until reset.
- Unused state codes 13–15 → FETCH on the next edge.
- Latency with mem_ready held at 1:
  - branch: 3 cycles
  - R-type, I-type, jal, lui, sw: 4 cycles
  - lw: 5 cycles
  - each mem_ready = 0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Reset mid-instruction: the FSM abandons the instruction with no write enables in the reset cycle and resumes at FETCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - The illegal path from DECODE goes to TRAP; illegal_instr is set on that edge.
  - illegal_instr stays 1 until reset.
  - No further fetches occur (PCWrite stays 0).
- Undefined:
  - The illegal path from DECODE goes to FETCH with no writes (the instruction executes as a NOP).
  - illegal_instr is tied to 0 and TRAP is unreachable.

Test Plan:
- reset=1 for 2 cycles, then add x3,x1,x2 (0x002081B3), mem_ready=1 → states 0,1,6,8,0; ALUControl=0x000 in EXECR; RegWrite=1 only in ALUWB.
- sub (0x402081B3) and srai (0x4030D193) → ALUControl=0x100 in EXECR and 0x105 in EXECI; addi (0x00108093) → 0x000.
- lw (0x0000A183) with mem_ready=0 for 3 cycles in MEMREAD → 8 total cycles; RegWrite=1 with ResultSrc=01 exactly once.
- beq with Zero=1 → PCWrite=1 in BRANCH, ALUControl=0x008. bne with Zero=0 → PCWrite=0, ALUControl=0x009. Both return to FETCH after 3 cycles.
- sw (0x0020A023) with mem_ready low for 2 cycles in MEMWRITE → MemWrite high for 3 consecutive cycles, AdrSrc=1, then FETCH.
- Illegal op 0x0000007F: with ILLEGAL_TRAP_EN → state=12, illegal_instr=1, reset clears both. Without it → back to FETCH with illegal_instr=0 and no writes.
